mcpu_core_flush_sequencer: RTL and testbench

//  Sequences the maintenance operations requested by the coprocessor: DL1C flush, IL1C flush and TLB clear.

---
 rtl/mcpu_core_flush_sequencer.sv | 112 +++++++++++
 tb/tb_mcpu_core_flush_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_flush_sequencer.sv
// rtl/mcpu_core_flush_sequencer.sv - L1 invalidate walker and TLB clear sequencer for coprocessor maintenance ops
module mcpu_core_flush_sequencer #(
    parameter int DL1C_SETS_LOG2 = 5,
    parameter int IL1C_SETS_LOG2 = 5
) (
    input  logic                      clkrst_core_clk,
    input  logic                      clkrst_core_rst_n,
    input  logic                      dl1c_flush,
    input  logic                      il1c_flush,
    input  logic                      tlb_clear,
    output logic                      dl1c_inv_valid,
    output logic [DL1C_SETS_LOG2-1:0] dl1c_inv_set,
    input  logic                      dl1c_inv_ready,
    output logic                      il1c_inv_valid,
    output logic [IL1C_SETS_LOG2-1:0] il1c_inv_set,
    input  logic                      il1c_inv_ready,
    output logic                      tlb_clear_out,
    output logic                      flush_stall,
    output logic                      flush_busy
);

    typedef enum logic [1:0] {IDLE, DWALK, IWALK, TCLR} state_e;

    localparam logic [DL1C_SETS_LOG2-1:0] D_LAST = {DL1C_SETS_LOG2{1'b1}};
    localparam logic [IL1C_SETS_LOG2-1:0] I_LAST = {IL1C_SETS_LOG2{1'b1}};
    localparam logic [DL1C_SETS_LOG2-1:0] D_ONE  = {{(DL1C_SETS_LOG2-1){1'b0}}, 1'b1};
    localparam logic [IL1C_SETS_LOG2-1:0] I_ONE  = {{(IL1C_SETS_LOG2-1){1'b0}}, 1'b1};

    state_e                    state_q, state_d;
    logic                      pend_d_q, pend_d_d;
    logic                      pend_i_q, pend_i_d;
    logic                      pend_t_q, pend_t_d;
    logic [DL1C_SETS_LOG2-1:0] dcnt_q, dcnt_d;
    logic [IL1C_SETS_LOG2-1:0] icnt_q, icnt_d;
    logic                      busy_q;

    logic want_d, want_i, want_t;
    logic d_hs, i_hs, op_done;

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q  <= IDLE;
            pend_d_q <= 1'b0;
            pend_i_q <= 1'b0;
            pend_t_q <= 1'b0;
            dcnt_q   <= '0;
            icnt_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_d_q <= pend_d_d;
            pend_i_q <= pend_i_d;
            pend_t_q <= pend_t_d;
            dcnt_q   <= dcnt_d;
            icnt_q   <= icnt_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Same-cycle strobes take part in selection so back-to-back ops have no bubble.
    always_comb begin
        want_d = pend_d_q | dl1c_flush;
        want_i = pend_i_q | il1c_flush;
        want_t = pend_t_q | tlb_clear;
        d_hs   = (state_q == DWALK) & dl1c_inv_ready;
        i_hs   = (state_q == IWALK) & il1c_inv_ready;

        case (state_q)
            IDLE:    op_done = 1'b1;
            DWALK:   op_done = d_hs & (dcnt_q == D_LAST);
            IWALK:   op_done = i_hs & (icnt_q == I_LAST);
            TCLR:    op_done = 1'b1;
            default: op_done = 1'b1;
        endcase

        state_d  = state_q;
        pend_d_d = want_d;
        pend_i_d = want_i;
        pend_t_d = want_t;
        dcnt_d   = d_hs ? dcnt_q + D_ONE : dcnt_q;
        icnt_d   = i_hs ? icnt_q + I_ONE : icnt_q;

        if (op_done) begin
            if (want_d) begin
                state_d  = DWALK;
                pend_d_d = 1'b0;
            end else if (want_i) begin
                state_d  = IWALK;
                pend_i_d = 1'b0;
            end else if (want_t) begin
                state_d  = TCLR;
                pend_t_d = 1'b0;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    // Stall is combinational so the instruction after a FLUSH is held in its issue cycle.
    always_comb begin
        dl1c_inv_valid = (state_q == DWALK);
        dl1c_inv_set   = dcnt_q;
        il1c_inv_valid = (state_q == IWALK);
        il1c_inv_set   = icnt_q;
        tlb_clear_out  = (state_q == TCLR);
        flush_busy     = busy_q;
        flush_stall    = clkrst_core_rst_n &
                         ((state_q != IDLE) | pend_d_q | pend_i_q | pend_t_q |
                          dl1c_flush | il1c_flush | tlb_clear);
    end

endmodule

// File: tb/tb_mcpu_core_flush_sequencer.sv
// tb/tb_mcpu_core_flush_sequencer.sv - self-checking bench for the flush sequencer
module tb_mcpu_core_flush_sequencer;

    localparam int N  = 5;
    localparam int NS = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dl1c_flush, il1c_flush, tlb_clear;
    logic         dl1c_inv_valid, il1c_inv_valid, tlb_clear_out;
    logic [N-1:0] dl1c_inv_set, il1c_inv_set;
    logic         dl1c_inv_ready, il1c_inv_ready;
    logic         flush_stall, flush_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mcpu_core_flush_sequencer #(.DL1C_SETS_LOG2(N), .IL1C_SETS_LOG2(N)) dut (
        .clkrst_core_clk  (clk),
        .clkrst_core_rst_n(rst_n),
        .dl1c_flush       (dl1c_flush),
        .il1c_flush       (il1c_flush),
        .tlb_clear        (tlb_clear),
        .dl1c_inv_valid   (dl1c_inv_valid),
        .dl1c_inv_set     (dl1c_inv_set),
        .dl1c_inv_ready   (dl1c_inv_ready),
        .il1c_inv_valid   (il1c_inv_valid),
        .il1c_inv_set     (il1c_inv_set),
        .il1c_inv_ready   (il1c_inv_ready),
        .tlb_clear_out    (tlb_clear_out),
        .flush_stall      (flush_stall),
        .flush_busy       (flush_busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: current job (0 none, 1 DL1C walk, 2 IL1C walk, 3 TLB clear), sets still to go, queued requests.
    int         m_op, m_rem;
    logic [2:0] m_want;
    int         n_op, n_rem;
    logic [2:0] n_want;
    logic       m_hs, m_fin;

    always @* begin
        n_want = m_want | {tlb_clear, il1c_flush, dl1c_flush};
        n_op   = m_op;
        n_rem  = m_rem;
        m_hs   = (m_op == 1 && dl1c_inv_ready) || (m_op == 2 && il1c_inv_ready);
        if (m_hs) n_rem = m_rem - 1;
        m_fin  = (m_op == 0) || (m_op == 3) || (m_hs && m_rem == 1);
        if (m_fin) begin
            if (n_want[0])      begin n_op = 1; n_rem = NS; n_want[0] = 1'b0; end
            else if (n_want[1]) begin n_op = 2; n_rem = NS; n_want[1] = 1'b0; end
            else if (n_want[2]) begin n_op = 3; n_rem = 1;  n_want[2] = 1'b0; end
            else                begin n_op = 0; n_rem = 0; end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op   <= 0;
            m_rem  <= 0;
            m_want <= 3'b000;
        end else begin
            m_op   <= n_op;
            m_rem  <= n_rem;
            m_want <= n_want;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("m_dvalid", dl1c_inv_valid, m_op == 1);
            chk("m_ivalid", il1c_inv_valid, m_op == 2);
            chk("m_tlb", tlb_clear_out, m_op == 3);
            chk("m_busy", flush_busy, m_op != 0);
            chk("m_stall", flush_stall,
                (m_op != 0) || (m_want != 3'b000) || dl1c_flush || il1c_flush || tlb_clear);
            if (m_op == 1) chk("m_dset", dl1c_inv_set, NS - m_rem);
            if (m_op == 2) chk("m_iset", il1c_inv_set, NS - m_rem);
            chk("m_excl", (dl1c_inv_valid + il1c_inv_valid + tlb_clear_out) > 1, 0);
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (flush_stall && k < 300) begin
            nc();
            k++;
        end
        chk("idle_timeout", k < 300, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, at;
        rst_n = 1'b0;
        dl1c_flush = 0; il1c_flush = 0; tlb_clear = 0;
        dl1c_inv_ready = 1; il1c_inv_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        chk("rst_stall", flush_stall, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_dvalid", dl1c_inv_valid, 0);
        chk("rst_ivalid", il1c_inv_valid, 0);
        chk("rst_tlb", tlb_clear_out, 0);
        nc();

        // single DL1C flush with ready tied high
        dl1c_flush = 1;
        #3 chk("t1_stall_c0", flush_stall, 1);
        chk("t1_dvalid_c0", dl1c_inv_valid, 0);
        nc();
        dl1c_flush = 0;
        for (int c = 1; c <= 32; c++) begin
            #3 chk("t1_dvalid", dl1c_inv_valid, 1);
            chk("t1_dset", dl1c_inv_set, c - 1);
            chk("t1_stall", flush_stall, 1);
            nc();
        end
        #3 chk("t1_stall_c33", flush_stall, 0);
        chk("t1_dvalid_c33", dl1c_inv_valid, 0);
        nc();

        // backpressure at set 7
        dl1c_flush = 1;
        nc();
        dl1c_flush = 0;
        for (int c = 1; c <= 7; c++) nc();
        dl1c_inv_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #3 chk("t2_hold_valid", dl1c_inv_valid, 1);
            chk("t2_hold_set", dl1c_inv_set, 7);
            nc();
        end
        dl1c_inv_ready = 1;
        #3 chk("t2_set7", dl1c_inv_set, 7);
        nc();
        #3 chk("t2_set8", dl1c_inv_set, 8);
        wait_idle();

        // all three strobes in one cycle
        dl1c_flush = 1; il1c_flush = 1; tlb_clear = 1;
        #3 chk("t3_stall_c0", flush_stall, 1);
        nc();
        dl1c_flush = 0; il1c_flush = 0; tlb_clear = 0;
        for (int c = 1; c <= 65; c++) begin
            #3;
            if (c <= 32) begin
                chk("t3_dvalid", dl1c_inv_valid, 1);
                chk("t3_dset", dl1c_inv_set, c - 1);
            end else if (c <= 64) begin
                chk("t3_ivalid", il1c_inv_valid, 1);
                chk("t3_iset", il1c_inv_set, c - 33);
            end else begin
                chk("t3_tlb", tlb_clear_out, 1);
            end
            chk("t3_stall", flush_stall, 1);
            nc();
        end
        #3 chk("t3_stall_end", flush_stall, 0);
        chk("t3_tlb_end", tlb_clear_out, 0);
        nc();

        // DL1C flush re-requested mid-walk forces a second full walk
        dl1c_flush = 1;
        nc();
        for (int c = 1; c <= 64; c++) begin
            dl1c_flush = (c == 21);
            #3 chk("t4_dvalid", dl1c_inv_valid, 1);
            chk("t4_dset", dl1c_inv_set, (c - 1) % 32);
            nc();
        end
        dl1c_flush = 0;
        #3 chk("t4_stall_end", flush_stall, 0);
        nc();

        // repeated TLB clears during an IL1C walk collapse to one
        il1c_flush = 1;
        nc();
        il1c_flush = 0;
        cnt = 0; at = 0;
        for (int c = 1; c <= 40; c++) begin
            tlb_clear = (c == 5 || c == 10);
            #3;
            if (tlb_clear_out) begin
                cnt++;
                at = c;
            end
            nc();
        end
        tlb_clear = 0;
        chk("t5_tlb_count", cnt, 1);
        chk("t5_tlb_cycle", at, 33);
        wait_idle();

        // asynchronous reset in the middle of an IL1C walk
        il1c_flush = 1;
        nc();
        il1c_flush = 0;
        for (int c = 1; c <= 12; c++) nc();
        #3 chk("t6_iset12", il1c_inv_set, 12);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ivalid", il1c_inv_valid, 0);
        chk("t6_rst_iset", il1c_inv_set, 0);
        chk("t6_rst_dvalid", dl1c_inv_valid, 0);
        chk("t6_rst_stall", flush_stall, 0);
        chk("t6_rst_busy", flush_busy, 0);
        chk("t6_rst_tlb", tlb_clear_out, 0);
        nc();
        nc();
        rst_n = 1'b1;
        nc();
        il1c_flush = 1;
        nc();
        il1c_flush = 0;
        #3 chk("t6_restart_valid", il1c_inv_valid, 1);
        chk("t6_restart_set", il1c_inv_set, 0);
        nc();
        wait_idle();
        nc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
